// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: UART transmitter states and data-path constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int DATA_W         = 8;
    localparam int UART_STOP_BITS = 1;

    // Transmitter FSM states; PARITY is only reachable in the 8E1 build.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/out_fifo.sv
// Synchronous byte FIFO between the CPU OUT strobe and the UART shifter.
// Latency: a push is visible at the head (level/full) one edge after it is written.
// Backpressure: none upstream; a push while full is dropped and latches the sticky overflow flag.
module out_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [W-1:0]              push_dat,
    input  logic                      pop,
    output logic [W-1:0]              head_dat,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          push_ok;
    logic          pop_ok;

    // full comes from the registered level, so a same-cycle pop never makes room for a push.
    assign full     = (level_q == LW'(DEPTH));
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & (level_q != '0);
    assign head_dat = mem_q[rd_ptr_q];
    assign level    = level_q;
    assign overflow = overflow_q;

    // Next-state for storage, pointers, occupancy and the sticky drop flag.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | (push & full);
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO registers; reset discards any queued bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: rtl/out_uart_tx.sv
// CPU OUT-port UART transmitter: buffers OUT bytes and sends 8N1 frames (8E1 with OUT_UART_PARITY_EN).
// Latency: start bit begins 1 cycle after the byte is written; frames are back-to-back with a 1-cycle idle gap.
// Backpressure: none toward the CPU; bytes arriving with the FIFO full are dropped and flagged in overflow.
module out_uart_tx
    import cpu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          out_valid,
    input  logic [7:0]                    out_data,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] STOP_LAST = 8'(CLKS_PER_BIT * UART_STOP_BITS - 1);

    uart_state_e       state_q, state_d;
    logic [7:0]        baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              pop;
    logic [DATA_W-1:0] head_dat;
    logic              baud_last;
`ifdef OUT_UART_PARITY_EN
    logic              par_q, par_d;
`endif

    out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (out_valid),
        .push_dat (out_data),
        .pop      (pop),
        .head_dat (head_dat),
        .level    (level),
        .full     (full),
        .overflow (overflow)
    );

    assign baud_last = (baud_q == BAUD_LAST);
    assign tx        = tx_q;
    assign busy      = (state_q != ST_IDLE) | (level != '0);

    // Frame sequencer: tx_d is computed for the state being entered so the pin is a pure flop.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + 8'd1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
`ifdef OUT_UART_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                baud_d = 8'd0;
                tx_d   = 1'b1;
                if (level != '0) begin
                    pop     = 1'b1;
                    shift_d = head_dat;
`ifdef OUT_UART_PARITY_EN
                    par_d   = ^head_dat;
`endif
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    state_d   = ST_DATA;
                    baud_d    = 8'd0;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_d    = 8'd0;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = par_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
`ifdef OUT_UART_PARITY_EN
            ST_PARITY: begin
                if (baud_last) begin
                    state_d = ST_STOP;
                    baud_d  = 8'd0;
                    tx_d    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (baud_q == STOP_LAST) begin
                    state_d = ST_IDLE;
                    baud_d  = 8'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = 8'd0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Sequencer registers; reset drives the line idle-high immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= 8'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef OUT_UART_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef OUT_UART_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule
